// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between instruction fetch
// and MEM-stage data access. One transaction at a time over a cyc/stb/ack
// handshake, with a bus timeout and fetch discard on pipeline flush.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus free; sample requests, data wins over fetch
// BUSY_I | fetch cycle on the bus, waiting for bus_ack_i or timeout
// BUSY_D | data cycle on the bus, waiting for bus_ack_i or timeout
// DONE   | one-cycle completion; owner ack asserted, no new grant
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,

  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,

  input  logic        flush_i,

  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,

  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter value seen in the last BUSY cycle allowed before abort; the
  // counter starts at 0 in the first strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        discard_q, discard_d;

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_ack_q, mem_ack_d;
  logic        err_q, err_d;

  logic        busy;
  logic        at_limit;
  logic        finish;
  logic        timed_out;
  logic        fetch_killed;

  assign busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign at_limit     = (cnt_q == CNT_LAST);
  assign finish       = busy && (bus_ack_i || at_limit);
  // A slave ack in the final allowed cycle still counts as a good completion.
  assign timed_out    = busy && !bus_ack_i && at_limit;
  // A flush arriving in the completing cycle also kills the fetch result.
  assign fetch_killed = discard_q || flush_i;

  // State register plus timeout counter and discard flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d = BUSY_D;
        end else if (if_req_i && !flush_i) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered bus, data, ack and error outputs.
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    if_ack_d    = 1'b0;
    if_data_d   = '0;
    mem_ack_d   = 1'b0;
    mem_rdata_d = '0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        cyc_d     = 1'b0;
        if (mem_req_i) begin
          cyc_d   = 1'b1;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
        end else if (if_req_i && !flush_i) begin
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          addr_d  = if_addr_i;
          wdata_d = '0;
        end
      end

      BUSY_I: begin
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (finish) begin
          cyc_d = 1'b0;
          cnt_d = '0;
          err_d = timed_out;
          if (!fetch_killed) begin
            if_ack_d = 1'b1;
            if (bus_ack_i) begin
              if_data_d = bus_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BUSY_D: begin
        if (finish) begin
          cyc_d     = 1'b0;
          cnt_d     = '0;
          err_d     = timed_out;
          mem_ack_d = 1'b1;
          if (bus_ack_i && !we_q) begin
            mem_rdata_d = bus_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        cyc_d     = 1'b0;
        cnt_d     = '0;
        discard_d = 1'b0;
      end

      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears everything, dropping any open bus cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;
  assign if_data_o   = if_data_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;

  // Stall requests are combinational so ctrl sees them in the request cycle.
  assign stallreq_if_o  = rst && if_req_i && !if_ack_q;
  assign stallreq_mem_o = rst && mem_req_i && !mem_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench. Stimulus pushes the expected bus
// transactions and owner responses; a slave process and a response monitor
// pop and compare independently.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        flush_i;
  logic        flush_slv = 1'b0;
  logic        flush_drv = 1'b0;
  logic        stallreq_if_o, stallreq_mem_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;

  assign flush_i = flush_slv | flush_drv;

  mem_bus_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .flush_i(flush_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  initial forever #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          lat;       // strobe cycles before ack; >= TO means never
    int          flush_at;  // strobe cycle index for a flush pulse, -1 none
    logic [31:0] rdata;
    bit          rst_abort; // cycle is expected to be cut short by reset
  } bus_exp_t;

  typedef struct {
    int          kind;      // 0 data ack, 1 fetch ack, 2 error pulse only
    logic [31:0] data;
    logic        err;
  } resp_t;

  bus_exp_t bus_q[$];
  resp_t    resp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_len(input int lat);
    return (lat < TO) ? lat + 1 : TO;
  endfunction

  // Slave: pops one expected transaction per bus cycle, checks the request,
  // answers after the planned latency and optionally pulses flush.
  bit       slv_active = 0;
  int       disc_cnt = 0;
  initial begin : slave
    bus_exp_t cur;
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      bus_ack_i   = 1'b0;
      flush_slv   = 1'b0;
      bus_rdata_i = $urandom();
      if (slv_active && !bus_cyc_o) begin
        slv_active = 0;
        if (!cur.rst_abort) chk("bus_cyc_len", k, exp_len(cur.lat));
        if (cur.flush_at >= 0) disc_cnt++;
      end
      if (!slv_active && bus_cyc_o) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_cycle", bus_cyc_o, 0);
        end else begin
          cur = bus_q.pop_front();
          slv_active = 1;
          k = 0;
        end
      end
      if (slv_active) begin
        chk("bus_stb", bus_stb_o, 1);
        chk("bus_addr", bus_addr_o, cur.addr);
        chk("bus_we", bus_we_o, cur.we);
        chk("bus_sel", bus_sel_o, cur.sel);
        chk("bus_wdata", bus_wdata_o, cur.wdata);
        if (k == cur.lat) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = cur.rdata;
        end
        if (k == cur.flush_at) flush_slv = 1'b1;
        k++;
      end
    end
  end

  // Monitor: every ack/error pulse must match the next expected response,
  // and data outputs must be back to 0 on the following cycle.
  initial begin : monitor
    resp_t e;
    bit prev_ev;
    prev_ev = 0;
    forever begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o || bus_err_o) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_ack_err", {29'd0, if_ack_o, mem_ack_o, bus_err_o}, 0);
        end else begin
          e = resp_q.pop_front();
          chk("if_ack", if_ack_o, (e.kind == 1));
          chk("mem_ack", mem_ack_o, (e.kind == 0));
          chk("bus_err", bus_err_o, e.err);
          if (e.kind == 0) chk("mem_rdata", mem_rdata_o, e.data);
          else chk("if_data", if_data_o, e.data);
        end
        prev_ev = 1;
      end else begin
        if (prev_ev) begin
          chk("if_data_cleared", if_data_o, 0);
          chk("mem_rdata_cleared", mem_rdata_o, 0);
        end
        prev_ev = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int t_mem_ack, t_if_ack, disc_seen = 0;
  int rises[$];

  // Queue expectations (data first on a simultaneous request) and drive.
  task automatic issue(input bit do_d, input logic d_we, input logic [3:0] d_sel,
                       input logic [31:0] d_addr, input logic [31:0] d_wdata,
                       input int d_lat, input logic [31:0] d_rdata,
                       input bit do_i, input logic [31:0] i_addr, input int i_lat,
                       input logic [31:0] i_rdata, input int i_flush);
    bus_exp_t b;
    resp_t r;
    if (do_d) begin
      b = '{addr: d_addr, we: d_we, sel: d_sel, wdata: d_wdata, lat: d_lat,
            flush_at: -1, rdata: d_rdata, rst_abort: 0};
      bus_q.push_back(b);
      r.kind = 0;
      r.err  = (d_lat >= TO);
      r.data = (r.err || d_we) ? 32'd0 : d_rdata;
      resp_q.push_back(r);
      mem_we_i = d_we; mem_sel_i = d_sel; mem_addr_i = d_addr; mem_wdata_i = d_wdata;
      mem_req_i = 1'b1;
    end
    if (do_i) begin
      b = '{addr: i_addr, we: 1'b0, sel: 4'hF, wdata: 32'd0, lat: i_lat,
            flush_at: i_flush, rdata: i_rdata, rst_abort: 0};
      bus_q.push_back(b);
      if (i_flush >= 0) begin
        if (i_lat >= TO) begin
          r = '{kind: 2, data: 32'd0, err: 1'b1};
          resp_q.push_back(r);
        end
      end else begin
        r.kind = 1;
        r.err  = (i_lat >= TO);
        r.data = r.err ? 32'd0 : i_rdata;
        resp_q.push_back(r);
      end
      if_addr_i = i_addr;
      if_req_i  = 1'b1;
    end
  endtask

  // Play the requester side until everything queued has completed.
  task automatic drain();
    int idle, n;
    bit prev;
    idle = 0; n = 0; prev = bus_cyc_o;
    t_mem_ack = -1; t_if_ack = -1;
    rises.delete();
    while (idle < 2 && n < 150) begin
      @(negedge clk);
      n++;
      chk("stallreq_if", stallreq_if_o, if_req_i && !if_ack_o);
      chk("stallreq_mem", stallreq_mem_o, mem_req_i && !mem_ack_o);
      if (bus_cyc_o && !prev) rises.push_back(cyc_n);
      prev = bus_cyc_o;
      if (mem_ack_o) begin mem_req_i = 1'b0; t_mem_ack = cyc_n; end
      if (if_ack_o) begin if_req_i = 1'b0; t_if_ack = cyc_n; end
      if (disc_cnt != disc_seen) begin disc_seen = disc_cnt; if_req_i = 1'b0; end
      if (!mem_req_i && !if_req_i && resp_q.size() == 0 && bus_q.size() == 0 &&
          !slv_active && !bus_cyc_o) idle++;
      else idle = 0;
    end
    if (idle < 2) chk("drain_timeout", idle, 2);
  endtask

  initial begin : stim
    int t0, n, il, dl, fa;
    bus_exp_t b;
    resp_t r;

    // Reset with random inputs: every output must read 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rst_ctrl", {20'd0, if_ack_o, mem_ack_o, stallreq_if_o, stallreq_mem_o,
                         bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o, bus_sel_o}, 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_mem_rdata", mem_rdata_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
      end
      if_req_i = 1'($urandom()); mem_req_i = 1'($urandom());
      if_addr_i = $urandom(); mem_addr_i = $urandom(); mem_wdata_i = $urandom();
      mem_sel_i = 4'($urandom()); mem_we_i = 1'($urandom()); flush_drv = 1'($urandom());
    end
    @(negedge clk);
    chk("rst_ctrl_last", {26'd0, if_ack_o, mem_ack_o, stallreq_if_o, stallreq_mem_o,
                          bus_cyc_o, bus_err_o}, 0);
    if_req_i = 1'b0; mem_req_i = 1'b0; flush_drv = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_cyc", bus_cyc_o, 0);
    end

    // Fetch, slave acks on the third strobe cycle.
    t0 = cyc_n;
    issue(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 2, 32'h3401_1100, -1);
    drain();
    chk("fetch_stb_time", (rises.size() > 0) ? rises[0] - t0 : -1, 1);
    chk("fetch_ack_time", t_if_ack - t0, 4);

    // Contention: zero-wait slave, data write wins.
    t0 = cyc_n;
    issue(1, 1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF, 0, 32'h5555_AAAA,
          1, 32'h0000_0300, 0, 32'h1111_2222, -1);
    drain();
    chk("cont_mem_ack_time", t_mem_ack - t0, 2);
    chk("cont_rises", rises.size(), 2);
    if (rises.size() >= 2) chk("cont_fetch_stb_time", rises[1] - t0, 4);
    chk("cont_if_ack_time", t_if_ack - t0, 5);

    // Flush during fetch: cycle completes, no if_ack; next fetch normal.
    issue(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0104, 3, 32'h0BAD_F00D, 0);
    drain();
    chk("flush_no_if_ack", t_if_ack, -1);
    t0 = cyc_n;
    issue(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0108, 1, 32'h0000_0013, -1);
    drain();
    chk("after_flush_ack_time", t_if_ack - t0, 3);

    // Flush in IDLE blocks only the fetch grant.
    issue(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_010C, 0, 32'h7777_0000, -1);
    flush_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_idle_no_grant", bus_cyc_o, 0);
    end
    flush_drv = 1'b0;
    t0 = cyc_n;
    drain();
    chk("flush_idle_release_ack", t_if_ack - t0, 2);

    // Timeout: data read never acked.
    t0 = cyc_n;
    issue(1, 0, 4'hF, 32'h0000_0500, 32'h0, 99, 32'h0, 0, 0, 0, 0, -1);
    drain();
    chk("timeout_ack_time", t_mem_ack - t0, 5);

    // Boundary: ack in the last allowed strobe cycle is not an error.
    issue(1, 0, 4'b0101, 32'h0000_0504, 32'h0, TO - 1, 32'hA5A5_5A5A, 0, 0, 0, 0, -1);
    drain();

    // Reset during BUSY_D, then the held request is served again.
    b = '{addr: 32'h0000_0400, we: 1'b0, sel: 4'b1100, wdata: 32'h0000_1234,
          lat: 99, flush_at: -1, rdata: 32'h0, rst_abort: 1};
    bus_q.push_back(b);
    mem_we_i = 1'b0; mem_sel_i = 4'b1100; mem_addr_i = 32'h0000_0400;
    mem_wdata_i = 32'h0000_1234; mem_req_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_cyc_o && n < 10);
    chk("rstmid_cycle_started", bus_cyc_o, 1);
    @(negedge clk);
    b.rst_abort = 0; b.lat = 1; b.rdata = 32'hCAFE_0001;
    bus_q.push_back(b);
    r = '{kind: 0, data: 32'hCAFE_0001, err: 1'b0};
    resp_q.push_back(r);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_cyc_stb", {30'd0, bus_cyc_o, bus_stb_o}, 0);
    chk("rstmid_no_ack_err", {29'd0, if_ack_o, mem_ack_o, bus_err_o}, 0);
    chk("rstmid_stall_mem", stallreq_mem_o, 0);
    rst = 1'b1;
    t0 = cyc_n;
    drain();
    chk("rstmid_reserve_ack_time", t_mem_ack - t0, 3);

    // Randomised mix.
    for (int it = 0; it < 40; it++) begin
      bit dd, di;
      dd = 1'($urandom());
      di = dd ? 1'($urandom()) : 1'b1;
      dl = $urandom_range(0, TO + 1);
      il = $urandom_range(0, TO + 1);
      if (dl > TO) dl = 99;
      if (il > TO) il = 99;
      fa = -1;
      if ($urandom_range(0, 3) == 0 && exp_len(il) >= 2) fa = $urandom_range(0, exp_len(il) - 2);
      issue(dd, 1'($urandom()), 4'($urandom()), $urandom(), $urandom(), dl, $urandom(),
            di, $urandom(), il, $urandom(), fa);
      drain();
    end

    repeat (3) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Single-master bus arbiter that shares one external memory bus between instruction fetch (IF/pc_reg side) and data access (MEM stage). It sequences one bus transaction at a time using a cyc/stb/ack handshake and returns read data plus a one-cycle ack to the owner. It raises per-requester stall requests to ctrl. It also enforces a bus timeout and supports discarding a fetch on pipeline flush.

Parameters:
TIMEOUT_CYC, 255, cycles in a BUSY state without bus_ack_i before the transaction is aborted (1..2^CNT_W-1)
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
if_req_i  in  1  fetch request; level, held until if_ack_o
if_addr_i  in  32  fetch address
if_data_o  out  32  fetched instruction; valid while if_ack_o=1
if_ack_o  out  1  one-cycle fetch completion pulse
mem_req_i  in  1  data request; level, held until mem_ack_o
mem_we_i  in  1  1=write, 0=read
mem_sel_i  in  4  byte enables
mem_addr_i  in  32  data address
mem_wdata_i  in  32  write data
mem_rdata_o  out  32  read data; valid while mem_ack_o=1
mem_ack_o  out  1  one-cycle data completion pulse
flush_i  in  1  pipeline flush; kills pending or in-flight fetch
stallreq_if_o  out  1  to ctrl: fetch pending
stallreq_mem_o  out  1  to ctrl: data access pending
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  strobe; equal to bus_cyc_o
bus_we_o  out  1  write enable
bus_sel_o  out  4  byte enables (4'b1111 for fetch)
bus_addr_o  out  32  address
bus_wdata_o  out  32  write data (0 for fetch)
bus_rdata_i  in  32  read data
bus_ack_i  in  1  slave completion; may arrive in first strobe cycle
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE. All bus_* outputs, data outputs, acks and bus_err_o are registered.
- Reset (rst=0 at a clock edge): state to IDLE; every output listed above is 0 after that edge; timeout counter and discard flag cleared. Reset mid-transaction drops bus_cyc_o/bus_stb_o at that edge, with no ack and no error.
- IDLE: if mem_req_i=1, go to BUSY_D and latch the mem_* inputs onto the bus outputs with bus_cyc_o=bus_stb_o=1. If mem_req_i=0, if_req_i=1 and flush_i=0, go to BUSY_I and latch if_addr_i, with we=0, sel=4'hF, wdata=0. Data has priority on a simultaneous request. Otherwise stay in IDLE.
- BUSY_x: bus outputs are held stable and the counter increments every cycle. On bus_ack_i=1: cyc/stb drop at that edge; read data is captured into if_data_o or mem_rdata_o (write: mem_rdata_o=0); go to DONE.
- DONE (exactly 1 cycle): the owner's ack is 1. No new grant is made and requests are not sampled. Next state is IDLE. Data and ack outputs return to 0 after DONE.
- Minimum latency: request seen in cycle 0 → stb in cycle 1 → ack_i in cycle 1 → ack_o in cycle 2. Back-to-back transactions start every 3 cycles at best.
- Timeout: if the counter reaches TIMEOUT_CYC in a BUSY state with no ack, abort. Drop cyc/stb, go to DONE with owner ack=1, data=0, bus_err_o=1 for the DONE cycle.
- flush_i=1 in IDLE: blocks the fetch grant only; a data grant is unaffected.
- flush_i=1 in BUSY_I: sets the discard flag, and the bus cycle still completes. On ack or timeout, go to DONE with if_ack_o=0 and if_data_o=0; bus_err_o still pulses on timeout. flush_i is ignored in BUSY_D.
- bus_ack_i outside BUSY states is ignored.
- Stall outputs (combinational): stallreq_if_o = if_req_i & ~if_ack_o; stallreq_mem_o = mem_req_i & ~mem_ack_o. Both are 0 while rst=0.
- Only one of if_ack_o and mem_ack_o is ever 1 in a cycle. bus_cyc_o is never 1 in IDLE or DONE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → all outputs 0; release with no requests → bus_cyc_o stays 0.
- Fetch: if_req_i=1, if_addr_i=32'h0000_0100; slave acks 2 cycles after stb with rdata=32'h3401_1100 → bus_addr_o=0x100, sel=F, we=0; if_ack_o=1 for one cycle with if_data_o=0x34011100; stallreq_if_o=1 until that cycle.
- Contention: if_req_i and mem_req_i (write, addr 0x200, wdata 0xDEADBEEF, sel 4'b0011) rise together; slave has zero-wait ack → data transaction is granted first (mem_ack_o at cycle 2); fetch stb starts at cycle 4; if_ack_o at cycle 5.
- Flush: fetch in BUSY_I, flush_i=1 for one cycle, ack arrives 3 cycles later → bus cycle completes; if_ack_o never asserts; IDLE follows DONE; the next fetch is accepted normally.
- Timeout: TIMEOUT_CYC=4, data read with slave never acking → cyc/stb high for exactly 4 cycles; then mem_ack_o=1, mem_rdata_o=0, bus_err_o=1 for one cycle.
- Reset mid-transaction: rst=0 during BUSY_D → cyc/stb=0 after the edge; no ack or error pulse; the request is re-served after rst=1.
